// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler
//   Queues SPI transaction requests (target slave index) and launches them one
//   at a time into a downstream SPI master. The downstream slave selects are
//   monitored to detect start, inter-element gaps and end of each transaction.
//
// Ports
//   clk                clock, rising edge
//   reset_n            asynchronous active-low reset
//   req_valid          upstream request valid
//   req_slave          binary slave index of the request
//   req_ready          queue can accept (not full)
//   start_transaction  one-cycle launch pulse to the SPI master
//   slave              binary index of the launched slave (held until next pop)
//   ss_n               slave selects from the SPI master (monitor only)
//   busy               FSM not in IDLE
//   done               one-cycle pulse at transaction completion
//   error              sticky error flag
//   err_clr            synchronous clear of error (a same-cycle set wins)
//   fifo_level         current queue occupancy
//
// Build option
//   SPI_TXN_SCHEDULER_WATCHDOG_EN : when defined, WAIT_SELECT is bounded by
//   START_TIMEOUT cycles; expiry flags error and returns to IDLE without done.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | waiting for a queued request; pops head onto slave
// LAUNCH      | start_transaction asserted for this single cycle
// WAIT_SELECT | waiting for the master to pull any ss_n low
// ACTIVE      | selects asserted; stray selects flag error
// QUIET       | all selects high; counting toward end of transaction

module spi_txn_scheduler #(
  parameter int NUMBER_OF_SLAVES = 2,
  parameter int FIFO_DEPTH       = 4,
  parameter int QUIET_CYCLES     = 4,
  parameter int START_TIMEOUT    = 16
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                req_valid,
  input  logic [NUMBER_OF_SLAVES-1:0]         req_slave,
  output logic                                req_ready,
  output logic                                start_transaction,
  output logic [NUMBER_OF_SLAVES-1:0]         slave,
  input  logic [NUMBER_OF_SLAVES-1:0]         ss_n,
  output logic                                busy,
  output logic                                done,
  output logic                                error,
  input  logic                                err_clr,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int QW = $clog2(QUIET_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_SELECT,
    S_ACTIVE,
    S_QUIET
  } state_t;

  // ---------------------------------------------------------------------------
  // Request queue
  // ---------------------------------------------------------------------------
  logic [NUMBER_OF_SLAVES-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [LW-1:0]               count;
  logic                        full;
  logic                        empty;
  logic                        req_bad;
  logic                        push;
  logic                        bad_req;
  logic                        pop;

  assign full      = (count == LW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign req_ready = !full;
  assign req_bad   = (int'(req_slave) >= NUMBER_OF_SLAVES);
  // Out-of-range requests complete the handshake but are dropped.
  assign push      = req_valid && !full && !req_bad;
  assign bad_req   = req_valid && !full && req_bad;
  assign fifo_level = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= req_slave;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop && !full) begin
        count <= count + LW'(1);
      end else if (pop && !push && !empty) begin
        count <= count - LW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  state_t                      state;
  state_t                      state_nxt;
  logic [QW-1:0]               quiet_cnt;
  logic [QW-1:0]               quiet_nxt;
  logic                        fsm_err;
  logic                        ss_idle;
  logic                        stray_sel;
  logic [NUMBER_OF_SLAVES-1:0] sel_mask;

`ifdef SPI_TXN_SCHEDULER_WATCHDOG_EN
  localparam int WW = $clog2(START_TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;
  logic [WW-1:0] wd_nxt;
`endif

  assign ss_idle = &ss_n;
  assign busy    = (state != S_IDLE);

  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < NUMBER_OF_SLAVES; i++) begin
      sel_mask[i] = (int'(slave) == i);
    end
  end

  // Any asserted select other than the launched slave's own bit.
  assign stray_sel = |(~ss_n & ~sel_mask);

  always_comb begin
    state_nxt         = state;
    quiet_nxt         = quiet_cnt;
    pop               = 1'b0;
    done              = 1'b0;
    start_transaction = 1'b0;
    fsm_err           = 1'b0;
`ifdef SPI_TXN_SCHEDULER_WATCHDOG_EN
    wd_nxt            = wd_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        start_transaction = 1'b1;
        state_nxt         = S_WAIT_SELECT;
`ifdef SPI_TXN_SCHEDULER_WATCHDOG_EN
        wd_nxt            = '0;
`endif
      end
      S_WAIT_SELECT: begin
`ifdef SPI_TXN_SCHEDULER_WATCHDOG_EN
        if (!ss_idle) begin
          state_nxt = S_ACTIVE;
        end else if (wd_cnt >= WW'(START_TIMEOUT - 1)) begin
          // Master never selected a slave: abandon without done.
          fsm_err   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          wd_nxt = wd_cnt + WW'(1);
        end
`else
        if (!ss_idle) begin
          state_nxt = S_ACTIVE;
        end
`endif
      end
      S_ACTIVE: begin
        if (stray_sel) begin
          fsm_err = 1'b1;
        end
        if (ss_idle) begin
          state_nxt = S_QUIET;
          quiet_nxt = QW'(1);
        end
      end
      S_QUIET: begin
        if (!ss_idle) begin
          // Gap between elements of the same transaction.
          state_nxt = S_ACTIVE;
        end else if (quiet_cnt >= QW'(QUIET_CYCLES)) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
          quiet_nxt = '0;
        end else begin
          quiet_nxt = quiet_cnt + QW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      quiet_cnt <= '0;
      slave     <= '0;
      error     <= 1'b0;
    end else begin
      state     <= state_nxt;
      quiet_cnt <= quiet_nxt;
      if (pop) begin
        slave <= mem[rd_ptr];
      end
      if (bad_req || fsm_err) begin
        error <= 1'b1;
      end else if (err_clr) begin
        error <= 1'b0;
      end
    end
  end

`ifdef SPI_TXN_SCHEDULER_WATCHDOG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_nxt;
    end
  end
`endif

endmodule
